n64_vdemux_ctrl: RTL and testbench

N64_VDEMUX_CTRL -- requirements
Module: n64_vdemux_ctrl

---
 rtl/n64_vdemux_ctrl_pkg.sv | 38 +++
 rtl/n64_sync_edge.sv | 21 ++
 rtl/n64_vdemux_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_n64_vdemux_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/n64_vdemux_ctrl_pkg.sv
// Shared definitions for the N64 video-bus demultiplexer: FSM encoding,
// per-cycle control bundle, and bit positions inside the 4-bit sync word.
package n64_vdemux_ctrl_pkg;

    // Default width of one colour component on the video bus
    localparam int COLOR_W_DEF = 7;

    // Sync word layout {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
    localparam int SYNC_W      = 4;
    localparam int IDX_NVSYNC  = 3;
    localparam int IDX_NCLAMP  = 2;
    localparam int IDX_NHSYNC  = 1;
    localparam int IDX_NCSYNC  = 0;

    // All sync lines inactive (high); also the "previous sync" after reset
    localparam logic [SYNC_W-1:0] SYNC_INACTIVE = 4'b1111;

    // Word-phase FSM: IDLE waits for a sync word, S_R/S_G/S_B take the three
    // colour words, S_END expects the next pixel's sync word immediately.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_R    = 3'd1,
        ST_G    = 3'd2,
        ST_B    = 3'd3,
        ST_END  = 3'd4
    } vd_state_t;

    // Decoded per-cycle actions produced by the FSM output logic.
    // cap_color[0] captures R, cap_color[1] captures G; B goes straight
    // from the bus into vdata on commit.
    typedef struct packed {
        logic       cap_sync;
        logic [1:0] cap_color;
        logic       commit;
        logic       frame_err;
    } vd_ctrl_t;

endpackage

// File: rtl/n64_sync_edge.sv
// Edge flags for the vertical and horizontal sync lines, computed from the
// previously committed sync word and the sync word about to be committed.
// Purely combinational; the caller decides when the flags matter.
module n64_sync_edge (
    input  logic vsync_prev,
    input  logic hsync_prev,
    input  logic vsync_cur,
    input  logic hsync_cur,
    output logic vsync_pos,
    output logic vsync_neg,
    output logic hsync_pos,
    output logic hsync_neg
);

    // Sync lines are active-low, so a posedge marks the end of a sync pulse
    assign vsync_pos = ~vsync_prev &  vsync_cur;
    assign vsync_neg =  vsync_prev & ~vsync_cur;
    assign hsync_pos = ~hsync_prev &  hsync_cur;
    assign hsync_neg =  hsync_prev & ~hsync_cur;

endmodule

// File: rtl/n64_vdemux_ctrl.sv
// N64 video-bus demultiplexer. The bus carries a sync word (flagged by
// nDSYNC low) followed by R, G and B words. A complete pixel is committed
// to vdata_o one cycle after its B word, along with pixel/line counters
// and a lock indicator that tracks consecutive well-formed pixels.
module n64_vdemux_ctrl
    import n64_vdemux_ctrl_pkg::*;
#(
    parameter int COLOR_W  = COLOR_W_DEF,
    parameter int CNT_W    = 10,
    parameter int LOCK_PIX = 4
) (
    input  logic                   VCLK,
    input  logic                   nRST,
    input  logic                   nDSYNC,
    input  logic [COLOR_W-1:0]     D_i,
    output logic [4+3*COLOR_W-1:0] vdata_o,
    output logic                   pix_valid_o,
    output logic [CNT_W-1:0]       hcnt_o,
    output logic [CNT_W-1:0]       vcnt_o,
    output logic                   lock_o,
    output logic                   frame_err_o
);

    localparam int VD_W = SYNC_W + 3*COLOR_W;
    localparam int WF_W = $clog2(LOCK_PIX + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [WF_W-1:0]  WF_LOCK  = WF_W'(LOCK_PIX);
    localparam logic [VD_W-1:0]  VD_RESET = {SYNC_INACTIVE, {(3*COLOR_W){1'b0}}};

    vd_state_t state_reg;
    vd_state_t state_next;
    vd_ctrl_t  ctrl;

    logic [SYNC_W-1:0]  sync_pend_reg;
    logic [COLOR_W-1:0] color_pend_reg [2];

    logic [VD_W-1:0]    vdata_reg;
    logic               pix_valid_reg;
    logic               frame_err_reg;
    logic [CNT_W-1:0]   hcnt_reg;
    logic [CNT_W-1:0]   hcnt_next;
    logic [CNT_W-1:0]   vcnt_reg;
    logic [CNT_W-1:0]   vcnt_next;
    logic [WF_W-1:0]    wf_cnt_reg;
    logic [WF_W-1:0]    wf_cnt_next;

    logic [SYNC_W-1:0]  sync_prev;
    logic               vs_pos;
    logic               vs_neg;
    logic               hs_pos;
    logic               hs_neg;
    logic               edge_unused;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: a sync word always restarts a pixel; data words step
    // through the colour phases; data in S_END means the stream broke off
    always_comb begin
        state_next = ST_IDLE;
        if (!nDSYNC) begin
            state_next = ST_R;
        end else begin
            case (state_reg)
                ST_R:    state_next = ST_G;
                ST_G:    state_next = ST_B;
                ST_B:    state_next = ST_END;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Output decode: which register captures this cycle, and whether the
    // current word completes a pixel or violates the framing
    always_comb begin
        ctrl = '0;
        if (!nDSYNC) begin
            ctrl.cap_sync  = 1'b1;
            ctrl.frame_err = (state_reg == ST_R) || (state_reg == ST_G) ||
                             (state_reg == ST_B);
        end else begin
            case (state_reg)
                ST_R:    ctrl.cap_color[0] = 1'b1;
                ST_G:    ctrl.cap_color[1] = 1'b1;
                ST_B:    ctrl.commit       = 1'b1;
                ST_END:  ctrl.frame_err    = 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pending pixel capture
    // ------------------------------------------------------------------

    // Pending sync word: only the low four bus bits carry sync lines
    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            sync_pend_reg <= SYNC_INACTIVE;
        end else if (ctrl.cap_sync) begin
            sync_pend_reg <= D_i[SYNC_W-1:0];
        end
    end

    // Pending R and G words, one lane each; B is taken from the bus on commit
    for (genvar gi = 0; gi < 2; gi++) begin : g_color_pend
        // Capture this lane's colour word in its phase
        always_ff @(posedge VCLK or negedge nRST) begin
            if (!nRST) begin
                color_pend_reg[gi] <= '0;
            end else if (ctrl.cap_color[gi]) begin
                color_pend_reg[gi] <= D_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sync edge detection against the last committed sync word
    // ------------------------------------------------------------------

    assign sync_prev = vdata_reg[VD_W-1 -: SYNC_W];

    n64_sync_edge u_sync_edge (
        .vsync_prev (sync_prev[IDX_NVSYNC]),
        .hsync_prev (sync_prev[IDX_NHSYNC]),
        .vsync_cur  (sync_pend_reg[IDX_NVSYNC]),
        .hsync_cur  (sync_pend_reg[IDX_NHSYNC]),
        .vsync_pos  (vs_pos),
        .vsync_neg  (vs_neg),
        .hsync_pos  (hs_pos),
        .hsync_neg  (hs_neg)
    );

    // Falling edges (start of a sync pulse) do not move the counters
    assign edge_unused = vs_neg ^ hs_neg;

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------

    // Pixel/line counter update applied on commit; end of vsync pulse wins
    // over a simultaneous end of hsync pulse for the line counter
    always_comb begin
        hcnt_next = hcnt_reg;
        vcnt_next = vcnt_reg;
        if (hs_pos) begin
            hcnt_next = '0;
        end else if (hcnt_reg != CNT_MAX) begin
            hcnt_next = hcnt_reg + CNT_W'(1);
        end
        if (vs_pos) begin
            vcnt_next = '0;
        end else if (hs_pos && (vcnt_reg != CNT_MAX)) begin
            vcnt_next = vcnt_reg + CNT_W'(1);
        end
    end

    // Well-formed pixel run length, saturating at the lock threshold
    always_comb begin
        wf_cnt_next = wf_cnt_reg;
        if (ctrl.frame_err) begin
            wf_cnt_next = '0;
        end else if (ctrl.commit && (wf_cnt_reg != WF_LOCK)) begin
            wf_cnt_next = wf_cnt_reg + WF_W'(1);
        end
    end

    // Committed pixel, counters and strobes; everything but the strobes
    // holds outside commit cycles
    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            vdata_reg     <= VD_RESET;
            pix_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            hcnt_reg      <= '0;
            vcnt_reg      <= '0;
            wf_cnt_reg    <= '0;
        end else begin
            pix_valid_reg <= ctrl.commit;
            frame_err_reg <= ctrl.frame_err;
            wf_cnt_reg    <= wf_cnt_next;
            if (ctrl.commit) begin
                vdata_reg <= {sync_pend_reg, color_pend_reg[0],
                              color_pend_reg[1], D_i};
                hcnt_reg  <= hcnt_next;
                vcnt_reg  <= vcnt_next;
            end
        end
    end

    assign vdata_o     = vdata_reg;
    assign pix_valid_o = pix_valid_reg;
    assign frame_err_o = frame_err_reg;
    assign hcnt_o      = hcnt_reg;
    assign vcnt_o      = vcnt_reg;
    assign lock_o      = (wf_cnt_reg == WF_LOCK);

endmodule

// File: tb/tb_n64_vdemux_ctrl.sv
// Scoreboard bench for n64_vdemux_ctrl: stimulus pushes expected pixels and
// expected framing errors into queues; a negedge monitor pops and compares
// whenever the DUT strobes pix_valid_o or frame_err_o.
module tb_n64_vdemux_ctrl;

    localparam int COLOR_W = 7;
    localparam int CNT_W   = 10;
    localparam int VD_W    = 4 + 3*COLOR_W;

    logic               VCLK   = 1'b0;
    logic               nRST   = 1'b0;
    logic               nDSYNC = 1'b1;
    logic [COLOR_W-1:0] D_i    = '0;
    logic [VD_W-1:0]    vdata_o;
    logic               pix_valid_o;
    logic [CNT_W-1:0]   hcnt_o;
    logic [CNT_W-1:0]   vcnt_o;
    logic               lock_o;
    logic               frame_err_o;

    n64_vdemux_ctrl dut (
        .VCLK        (VCLK),
        .nRST        (nRST),
        .nDSYNC      (nDSYNC),
        .D_i         (D_i),
        .vdata_o     (vdata_o),
        .pix_valid_o (pix_valid_o),
        .hcnt_o      (hcnt_o),
        .vcnt_o      (vcnt_o),
        .lock_o      (lock_o),
        .frame_err_o (frame_err_o)
    );

    always #5 VCLK = ~VCLK;

    typedef struct packed {
        logic [VD_W-1:0]  vdata;
        logic [CNT_W-1:0] h;
        logic [CNT_W-1:0] v;
        logic             lock;
    } pix_t;

    pix_t pix_q[$];
    int   err_q[$];
    pix_t mon_e;
    int   mon_tag;

    int checks   = 0;
    int failures = 0;

    // Reference state of the expected output stream
    logic [3:0]       m_prev;
    logic [CNT_W-1:0] m_h;
    logic [CNT_W-1:0] m_v;
    int               m_wf;
    logic [VD_W-1:0]  m_vdata;
    bit               after_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_prev  = 4'hF;
        m_h     = '0;
        m_v     = '0;
        m_wf    = 0;
        m_vdata = {4'hF, 21'b0};
        after_b = 1'b0;
    endtask

    task automatic drive(input logic ds, input logic [COLOR_W-1:0] d);
        @(posedge VCLK);
        #1;
        nDSYNC = ds;
        D_i    = d;
    endtask

    // One complete pixel: sync, R, G, B; expectation pushed before B
    task automatic pixel(input logic [3:0] s, input logic [6:0] r,
                         input logic [6:0] g, input logic [6:0] b);
        pix_t e;
        logic hpos;
        logic vpos;
        drive(1'b0, {3'b000, s});
        after_b = 1'b0;
        drive(1'b1, r);
        drive(1'b1, g);
        hpos = ~m_prev[1] & s[1];
        vpos = ~m_prev[3] & s[3];
        if (hpos) m_h = '0;
        else if (m_h != 10'h3FF) m_h = m_h + 10'd1;
        if (vpos) m_v = '0;
        else if (hpos && (m_v != 10'h3FF)) m_v = m_v + 10'd1;
        if (m_wf < 4) m_wf++;
        m_prev  = s;
        m_vdata = {s, r, g, b};
        e.vdata = m_vdata;
        e.h     = m_h;
        e.v     = m_v;
        e.lock  = (m_wf == 4);
        pix_q.push_back(e);
        drive(1'b1, b);
        after_b = 1'b1;
    endtask

    task automatic push_err();
        err_q.push_back(1);
        m_wf = 0;
    endtask

    // Bus idle; if a pixel just ended the missing sync word is an error
    task automatic idle(input int n);
        if (after_b) begin
            push_err();
            after_b = 1'b0;
        end
        repeat (n) drive(1'b1, 7'h00);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vdata"},     vdata_o,     {4'hF, 21'b0});
        check({tag, "_pix_valid"}, pix_valid_o, 1'b0);
        check({tag, "_frame_err"}, frame_err_o, 1'b0);
        check({tag, "_hcnt"},      hcnt_o,      10'd0);
        check({tag, "_vcnt"},      vcnt_o,      10'd0);
        check({tag, "_lock"},      lock_o,      1'b0);
    endtask

    // Monitor: compare every strobe against the head of its queue
    always @(negedge VCLK) begin
        if (nRST) begin
            if (pix_valid_o) begin
                if (pix_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pix actual=%h required=none", vdata_o);
                end else begin
                    mon_e = pix_q.pop_front();
                    $display("pix vdata=%h h=%0d v=%0d lock=%0b", vdata_o, hcnt_o, vcnt_o, lock_o);
                    check("pix_vdata", vdata_o, mon_e.vdata);
                    check("pix_hcnt",  hcnt_o,  mon_e.h);
                    check("pix_vcnt",  vcnt_o,  mon_e.v);
                    check("pix_lock",  lock_o,  mon_e.lock);
                end
            end
            if (frame_err_o) begin
                if (err_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame_err actual=1 required=0");
                end else begin
                    mon_tag = err_q.pop_front();
                    $display("frame_err tag=%0d lock=%0b vdata=%h", mon_tag, lock_o, vdata_o);
                    check("err_lock",       lock_o,      1'b0);
                    check("err_pix_valid",  pix_valid_o, 1'b0);
                    check("err_vdata_hold", vdata_o,     m_vdata);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge VCLK);
        @(negedge VCLK);
        check_reset_outputs("rst");
        @(posedge VCLK);
        #1 nRST = 1'b1;

        // First pixel: commit one cycle after B, hcnt 0 -> 1
        pixel(4'hF, 7'h11, 7'h22, 7'h33);
        idle(3);
        check("t1_vdata", vdata_o, {4'hF, 7'h11, 7'h22, 7'h33});
        check("t1_hcnt",  hcnt_o,  10'd1);
        check("t1_vcnt",  vcnt_o,  10'd0);

        // Four clean pixels reach lock; abort in S_G drops it
        pixel(4'hF, 7'h01, 7'h02, 7'h03);
        pixel(4'hF, 7'h04, 7'h05, 7'h06);
        pixel(4'hF, 7'h07, 7'h08, 7'h09);
        pixel(4'hF, 7'h0A, 7'h0B, 7'h0C);
        drive(1'b0, 7'h0F);
        after_b = 1'b0;
        drive(1'b1, 7'h55);
        push_err();
        pixel(4'hF, 7'h66, 7'h77, 7'h78);
        idle(3);
        check("t2_hcnt",  hcnt_o,  10'd6);
        check("t2_lock",  lock_o,  1'b0);
        check("t2_vdata", vdata_o, {4'hF, 7'h66, 7'h77, 7'h78});

        // End of hsync pulse: new line
        pixel(4'hD, 7'h10, 7'h20, 7'h30);
        pixel(4'hF, 7'h11, 7'h21, 7'h31);
        idle(3);
        check("t3_hcnt", hcnt_o, 10'd0);
        check("t3_vcnt", vcnt_o, 10'd1);

        // vsync and hsync end together: field restart wins
        pixel(4'h5, 7'h12, 7'h22, 7'h32);
        pixel(4'hF, 7'h13, 7'h23, 7'h33);
        idle(3);
        check("t4_hcnt", hcnt_o, 10'd0);
        check("t4_vcnt", vcnt_o, 10'd0);

        // vsync ends alone: vcnt cleared, hcnt keeps counting
        pixel(4'hD, 7'h14, 7'h24, 7'h34);
        pixel(4'hF, 7'h15, 7'h25, 7'h35);
        pixel(4'h7, 7'h16, 7'h26, 7'h36);
        pixel(4'hF, 7'h17, 7'h27, 7'h37);
        idle(3);
        check("t5_hcnt", hcnt_o, 10'd2);
        check("t5_vcnt", vcnt_o, 10'd0);

        // 1100 pixels without an hsync edge: hcnt saturates at 1023
        for (int i = 0; i < 1100; i++) begin
            pixel(4'hF, 7'(i), 7'(i + 1), 7'(i + 2));
        end
        idle(3);
        check("t6_hcnt", hcnt_o, 10'd1023);

        // Bus idles after a pixel: one error, then capture resumes
        pixel(4'hF, 7'h41, 7'h42, 7'h43);
        idle(5);
        pixel(4'hF, 7'h44, 7'h45, 7'h46);
        idle(3);
        check("t7_vdata", vdata_o, {4'hF, 7'h44, 7'h45, 7'h46});
        check("t7_hcnt",  hcnt_o,  10'd1023);

        // Reset asserted in S_G, released mid-pixel
        drive(1'b0, 7'h0F);
        drive(1'b1, 7'h21);
        drive(1'b1, 7'h22);
        #1 nRST = 1'b0;
        @(negedge VCLK);
        check_reset_outputs("mid_rst");
        repeat (2) @(posedge VCLK);
        #1 nRST = 1'b1;
        model_reset();
        drive(1'b1, 7'h23);
        drive(1'b1, 7'h00);
        pixel(4'hF, 7'h31, 7'h32, 7'h33);
        idle(3);
        check("t8_hcnt",  hcnt_o,  10'd1);
        check("t8_vcnt",  vcnt_o,  10'd0);
        check("t8_vdata", vdata_o, {4'hF, 7'h31, 7'h32, 7'h33});

        repeat (5) @(posedge VCLK);
        check("pix_q_drained", pix_q.size(), 0);
        check("err_q_drained", err_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
